pe_sequencer: RTL
=================

Name: pe_sequencer

Overview:
- Initiator-side controller for the background-removal processing element (pe); drives the pe's Start_Sum / Start_BgRemoval / Ack handshake and consumes its done states.
- Walks a pixel buffer in two passes. Pass 1 sums every pixel through the pe and derives the expected background colour (channel mean). Pass 2 runs background removal on every pixel using that mean and writes results back.
- Sits between the frame pixel buffer and a single pe instance. Replaces the hand-sequenced stimulus currently used for the pe.

Parameters:
- LOG2_PIXELS, 2, log2 of pixel count per frame; NUM_PIXELS = 2**LOG2_PIXELS.
- TIMEOUT_CYCLES, 64, watchdog limit per pe operation; used only with SEQ_TIMEOUT_EN.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Go  in  1  start a frame; sampled only in IDLE.
- Threshold_In  in  9  threshold forwarded to pe.
- Bg_R, Bg_G, Bg_B  in  9 each  replacement background colour.
- Busy  out  1  high from the cycle after Go is accepted until DONE.
- Done  out  1  one-cycle pulse at frame end.
- Error  out  1  sticky watchdog flag; tied 0 without SEQ_TIMEOUT_EN.
- Pix_Addr  out  LOG2_PIXELS  buffer read address; synchronous read, data valid one cycle later.
- Pix_R, Pix_G, Pix_B  in  9 each  buffer read data.
- Wr_En  out  1  one-cycle write strobe.
- Wr_Addr  out  LOG2_PIXELS  write address.
- Wr_R, Wr_G, Wr_B  out  9 each  write data.
- Pe_Start_Sum, Pe_Start_BgRemoval, Pe_Ack  out  1 each  pe controls.
- Pe_Red_In, Pe_Green_In, Pe_Blue_In  out  9 each  pixel to pe; held stable through the operation.
- Pe_Red_Exp, Pe_Green_Exp, Pe_Blue_Exp, Pe_Threshold, Pe_Bg_R, Pe_Bg_G, Pe_Bg_B  out  9 each  pe configuration.
- Pe_Sum_Done, Pe_Bg_Done  in  1 each  pe done states (Qsd, Qbgd).
- Pe_Red_Sum, Pe_Green_Sum, Pe_Blue_Sum  in  9 each  pe sum result.
- Pe_Red_Out, Pe_Green_Out, Pe_Blue_Out  in  9 each  pe output pixel.

Behaviour:
- Reset: state IDLE.
  - Busy, Done, Error, Wr_En and all Pe_Start_* / Pe_Ack are 0.
  - Addresses, accumulators and all data outputs are 0.
  - Reset in any state aborts the frame. No write occurs in the reset cycle.
- Go is accepted only in IDLE. Go while Busy is ignored.
- On accepting Go, latch Threshold_In and Bg_* for the whole frame. The accumulators and pixel index are cleared.
- States: IDLE -> S_RD -> S_GO -> S_WAIT -> S_ACK -> (S_RD | AVG) -> B_RD -> B_GO -> B_WAIT -> B_ACK -> (B_RD | FIN) -> IDLE.
- S_RD / B_RD:
  - Drive Pix_Addr = index.
  - Next cycle, register Pix_* into Pe_*_In.
- S_GO / B_GO:
  - Pulse Pe_Start_Sum (or Pe_Start_BgRemoval) for exactly one cycle.
  - Pe_*_In are already valid in that cycle.
- S_WAIT / B_WAIT: wait for Pe_Sum_Done (or Pe_Bg_Done) high.
  - S_WAIT on done: add Pe_*_Sum to the (9+LOG2_PIXELS)-bit channel accumulators. No overflow is possible.
  - B_WAIT on done: one-cycle Wr_En with Wr_Addr = index and Wr_* = Pe_*_Out.
- S_ACK / B_ACK:
  - Hold Pe_Ack high until the pe done input is sampled low, then drop Pe_Ack.
  - If index = NUM_PIXELS-1, advance to the next phase; otherwise index+1 and return to the read state.
- AVG (1 cycle):
  - Pe_*_Exp = accumulator >> LOG2_PIXELS, truncated.
  - Pe_Threshold and Pe_Bg_* are driven from the latched values.
  - Index resets to 0.
- FIN: pulse Done, Busy=0, return to IDLE.
- Done-flag edge cases:
  - If the done flag is already high on entry to S_WAIT/B_WAIT (pe still in a previous done state), it is treated as valid completion.
  - A pe that never drops its done flag holds the sequencer in S_ACK/B_ACK (unless the watchdog is enabled).
- Latency with a pe of D-cycle operation: per pixel 4+D+1 cycles minimum per pass, plus 1 AVG cycle and 1 FIN cycle.

Optional Feature:
- SEQ_TIMEOUT_EN defined:
  - A counter runs in S_WAIT, S_ACK, B_WAIT and B_ACK.
  - Reaching TIMEOUT_CYCLES sets Error (sticky until Reset or the next accepted Go), drops Pe_Ack and goes to FIN (Done pulses).
  - No write is issued for the timed-out pixel.
- SEQ_TIMEOUT_EN undefined: no counter; Error is constant 0; waits are unbounded.

Test Plan:
- All 4 pixels (61,133,198), threshold 30, Bg (10,10,10), pe model replaces when every |diff| <= threshold -> Pe_*_Exp = (61,133,198); 4 writes of (10,10,10) at addresses 0..3; one Done pulse.
- Pixels (61,133,198) x3 plus (200,20,20) -> exp = (95,104,153) (truncated). Pixels with every channel within 30 of exp are replaced; others are written unchanged.
- pe model done delay of 1 vs 7 cycles, Ack held 3 cycles by slow done drop -> Start pulses are exactly 1 cycle; Ack deasserts one cycle after done low; results identical.
- Go pulsed again mid-frame -> ignored; frame completes normally; exactly 4 writes.
- Reset asserted in B_WAIT of pixel 2 -> next cycle all outputs 0 and IDLE; no further writes; new Go runs a full frame correctly.
- SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=64 and a pe that never asserts done -> Error=1 and Done pulse after 64 waiting cycles; Wr_En never asserted.

Source files
------------

// File: rtl/pe_sequencer_if.sv
// pe_sequencer_if: signal bundle between pe_sequencer (master) and one
// background-removal pe (slave).
//
// Handshake: the master pulses Pe_Start_Sum or Pe_Start_BgRemoval for exactly
// one cycle while Pe_*_In and the configuration are already stable. The pe
// answers by raising its done flag (Pe_Sum_Done / Pe_Bg_Done) with its
// results valid for as long as that flag stays high. The master consumes the
// results in the first cycle it samples the flag high, then raises Pe_Ack and
// keeps it high until it samples the flag low; Pe_Ack drops on the following
// edge. No new start is issued while Pe_Ack is high.
interface pe_sequencer_if;
    logic       Pe_Start_Sum;
    logic       Pe_Start_BgRemoval;
    logic       Pe_Ack;
    logic [8:0] Pe_Red_In;
    logic [8:0] Pe_Green_In;
    logic [8:0] Pe_Blue_In;
    logic [8:0] Pe_Red_Exp;
    logic [8:0] Pe_Green_Exp;
    logic [8:0] Pe_Blue_Exp;
    logic [8:0] Pe_Threshold;
    logic [8:0] Pe_Bg_R;
    logic [8:0] Pe_Bg_G;
    logic [8:0] Pe_Bg_B;
    logic       Pe_Sum_Done;
    logic       Pe_Bg_Done;
    logic [8:0] Pe_Red_Sum;
    logic [8:0] Pe_Green_Sum;
    logic [8:0] Pe_Blue_Sum;
    logic [8:0] Pe_Red_Out;
    logic [8:0] Pe_Green_Out;
    logic [8:0] Pe_Blue_Out;

    modport master (
        output Pe_Start_Sum, Pe_Start_BgRemoval, Pe_Ack,
        output Pe_Red_In, Pe_Green_In, Pe_Blue_In,
        output Pe_Red_Exp, Pe_Green_Exp, Pe_Blue_Exp,
        output Pe_Threshold, Pe_Bg_R, Pe_Bg_G, Pe_Bg_B,
        input  Pe_Sum_Done, Pe_Bg_Done,
        input  Pe_Red_Sum, Pe_Green_Sum, Pe_Blue_Sum,
        input  Pe_Red_Out, Pe_Green_Out, Pe_Blue_Out
    );

    modport slave (
        input  Pe_Start_Sum, Pe_Start_BgRemoval, Pe_Ack,
        input  Pe_Red_In, Pe_Green_In, Pe_Blue_In,
        input  Pe_Red_Exp, Pe_Green_Exp, Pe_Blue_Exp,
        input  Pe_Threshold, Pe_Bg_R, Pe_Bg_G, Pe_Bg_B,
        output Pe_Sum_Done, Pe_Bg_Done,
        output Pe_Red_Sum, Pe_Green_Sum, Pe_Blue_Sum,
        output Pe_Red_Out, Pe_Green_Out, Pe_Blue_Out
    );
endinterface

// File: rtl/pe_sequencer.sv
// pe_sequencer: initiator-side controller for the background-removal pe.
// Pass 1 pushes every pixel through the pe's sum operation and averages the
// per-channel sums into the expected background colour. Pass 2 runs
// background removal on every pixel with that colour and writes the results
// back to the pixel buffer.
// Optional feature: define SEQ_TIMEOUT_EN to add a per-operation watchdog
// (TIMEOUT_CYCLES) that aborts the frame and raises a sticky Error.
// fsm_state exposes the current state encoding for debug and checkers.
module pe_sequencer #(
    parameter int LOG2_PIXELS    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Go,
    input  logic [8:0]             Threshold_In,
    input  logic [8:0]             Bg_R,
    input  logic [8:0]             Bg_G,
    input  logic [8:0]             Bg_B,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Error,
    output logic [LOG2_PIXELS-1:0] Pix_Addr,
    input  logic [8:0]             Pix_R,
    input  logic [8:0]             Pix_G,
    input  logic [8:0]             Pix_B,
    output logic                   Wr_En,
    output logic [LOG2_PIXELS-1:0] Wr_Addr,
    output logic [8:0]             Wr_R,
    output logic [8:0]             Wr_G,
    output logic [8:0]             Wr_B,
    pe_sequencer_if.master         pe,
    output logic [3:0]             fsm_state
);

    // Sum of NUM_PIXELS 9-bit values never exceeds 9+LOG2_PIXELS bits.
    localparam int ACC_W = 9 + LOG2_PIXELS;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        S_RD   = 4'd1,
        S_GO   = 4'd2,
        S_WAIT = 4'd3,
        S_ACK  = 4'd4,
        AVG    = 4'd5,
        B_RD   = 4'd6,
        B_GO   = 4'd7,
        B_WAIT = 4'd8,
        B_ACK  = 4'd9,
        FIN    = 4'd10
    } state_t;

    state_t                 state;
    logic [LOG2_PIXELS-1:0] index;
    // The buffer read is synchronous: the read states take two cycles, one to
    // present the address and one to capture the returned pixel.
    logic                   rd_wait;
    logic [8:0]             thr_q;
    logic [8:0]             bg_r_q;
    logic [8:0]             bg_g_q;
    logic [8:0]             bg_b_q;
    logic [ACC_W-1:0]       acc_r;
    logic [ACC_W-1:0]       acc_g;
    logic [ACC_W-1:0]       acc_b;
    logic                   in_bg_pass;
    logic                   done_in;
    logic                   last_pixel;

`ifdef SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    // The watchdog fires in the TIMEOUT_CYCLES-th waiting cycle of an operation.
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign Error = 1'b0;
`endif

    // Select the done flag belonging to the operation currently in flight.
    always_comb begin
        in_bg_pass = (state == B_WAIT) || (state == B_ACK);
        done_in    = in_bg_pass ? pe.Pe_Bg_Done : pe.Pe_Sum_Done;
    end

    assign last_pixel = &index;
    assign fsm_state  = state;

    // Frame sequencer: state, pixel walk, accumulation and every registered output.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state                 <= IDLE;
            index                 <= '0;
            rd_wait               <= 1'b0;
            thr_q                 <= '0;
            bg_r_q                <= '0;
            bg_g_q                <= '0;
            bg_b_q                <= '0;
            acc_r                 <= '0;
            acc_g                 <= '0;
            acc_b                 <= '0;
            Busy                  <= 1'b0;
            Done                  <= 1'b0;
            Pix_Addr              <= '0;
            Wr_En                 <= 1'b0;
            Wr_Addr               <= '0;
            Wr_R                  <= '0;
            Wr_G                  <= '0;
            Wr_B                  <= '0;
            pe.Pe_Start_Sum       <= 1'b0;
            pe.Pe_Start_BgRemoval <= 1'b0;
            pe.Pe_Ack             <= 1'b0;
            pe.Pe_Red_In          <= '0;
            pe.Pe_Green_In        <= '0;
            pe.Pe_Blue_In         <= '0;
            pe.Pe_Red_Exp         <= '0;
            pe.Pe_Green_Exp       <= '0;
            pe.Pe_Blue_Exp        <= '0;
            pe.Pe_Threshold       <= '0;
            pe.Pe_Bg_R            <= '0;
            pe.Pe_Bg_G            <= '0;
            pe.Pe_Bg_B            <= '0;
`ifdef SEQ_TIMEOUT_EN
            Error                 <= 1'b0;
            tmo_cnt               <= '0;
`endif
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            Done                  <= 1'b0;
            Wr_En                 <= 1'b0;
            pe.Pe_Start_Sum       <= 1'b0;
            pe.Pe_Start_BgRemoval <= 1'b0;

            case (state)
                IDLE: begin
                    if (Go) begin
                        thr_q    <= Threshold_In;
                        bg_r_q   <= Bg_R;
                        bg_g_q   <= Bg_G;
                        bg_b_q   <= Bg_B;
                        acc_r    <= '0;
                        acc_g    <= '0;
                        acc_b    <= '0;
                        index    <= '0;
                        Pix_Addr <= '0;
                        rd_wait  <= 1'b0;
                        Busy     <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                        Error    <= 1'b0;
`endif
                        state    <= S_RD;
                    end
                end

                S_RD, B_RD: begin
                    if (!rd_wait) begin
                        rd_wait <= 1'b1;
                    end else begin
                        // Pixel data is valid now; hold it on the pe inputs
                        // for the whole operation and raise the start pulse.
                        rd_wait         <= 1'b0;
                        pe.Pe_Red_In    <= Pix_R;
                        pe.Pe_Green_In  <= Pix_G;
                        pe.Pe_Blue_In   <= Pix_B;
                        if (state == S_RD) begin
                            pe.Pe_Start_Sum <= 1'b1;
                            state           <= S_GO;
                        end else begin
                            pe.Pe_Start_BgRemoval <= 1'b1;
                            state                 <= B_GO;
                        end
                    end
                end

                S_GO, B_GO: begin
`ifdef SEQ_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= (state == S_GO) ? S_WAIT : B_WAIT;
                end

                S_WAIT, B_WAIT: begin
                    // A done flag already high on entry counts as completion.
                    if (done_in) begin
                        if (state == S_WAIT) begin
                            acc_r <= acc_r + ACC_W'(pe.Pe_Red_Sum);
                            acc_g <= acc_g + ACC_W'(pe.Pe_Green_Sum);
                            acc_b <= acc_b + ACC_W'(pe.Pe_Blue_Sum);
                            state <= S_ACK;
                        end else begin
                            Wr_En   <= 1'b1;
                            Wr_Addr <= index;
                            Wr_R    <= pe.Pe_Red_Out;
                            Wr_G    <= pe.Pe_Green_Out;
                            Wr_B    <= pe.Pe_Blue_Out;
                            state   <= B_ACK;
                        end
                        pe.Pe_Ack <= 1'b1;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        Error     <= 1'b1;
                        pe.Pe_Ack <= 1'b0;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        state     <= FIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                S_ACK, B_ACK: begin
                    // Ack stays up until the pe is seen to leave its done state.
                    if (!done_in) begin
                        pe.Pe_Ack <= 1'b0;
                        if (last_pixel) begin
                            if (state == S_ACK) begin
                                state <= AVG;
                            end else begin
                                Busy  <= 1'b0;
                                Done  <= 1'b1;
                                state <= FIN;
                            end
                        end else begin
                            index    <= index + LOG2_PIXELS'(1);
                            Pix_Addr <= index + LOG2_PIXELS'(1);
                            state    <= (state == S_ACK) ? S_RD : B_RD;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        Error     <= 1'b1;
                        pe.Pe_Ack <= 1'b0;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        state     <= FIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                AVG: begin
                    // Channel mean, truncated: drop the LOG2_PIXELS low bits.
                    pe.Pe_Red_Exp   <= acc_r[ACC_W-1:LOG2_PIXELS];
                    pe.Pe_Green_Exp <= acc_g[ACC_W-1:LOG2_PIXELS];
                    pe.Pe_Blue_Exp  <= acc_b[ACC_W-1:LOG2_PIXELS];
                    pe.Pe_Threshold <= thr_q;
                    pe.Pe_Bg_R      <= bg_r_q;
                    pe.Pe_Bg_G      <= bg_g_q;
                    pe.Pe_Bg_B      <= bg_b_q;
                    index           <= '0;
                    Pix_Addr        <= '0;
                    rd_wait         <= 1'b0;
                    state           <= B_RD;
                end

                FIN: begin
                    // Done is high during this cycle; it was set on entry.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
